// File: rtl/cache_pkg.sv
// Shared cache definitions: LRU sequencer states, width helpers and default geometry.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } lru_state_e;

  localparam int DEF_A_SIZE = 8;
  localparam int DEF_SETS   = 64;

  function automatic int way_w(input int a_size);
    return $clog2(a_size);
  endfunction

  function automatic int lru_w(input int a_size);
    return a_size - 1;
  endfunction

endpackage

// File: rtl/plru_victim.sv
// Tree pseudo-LRU victim walk: each node bit marks the MRU side, so the victim follows the opposite side.
module plru_victim
  import cache_pkg::*;
#(
  parameter int a_size = DEF_A_SIZE
) (
  input  logic [a_size-2:0]         lru_i,
  output logic [$clog2(a_size)-1:0] victim_o
);

  localparam int WAY_W = way_w(a_size);

  // Padded to a power of two so a WAY_W-bit node index always lands in range.
  logic [a_size-1:0] tree;
  logic [WAY_W-1:0]  node;
  logic [WAY_W:0]    nxt;
  logic              b;

  assign tree = {1'b0, lru_i};

  always_comb begin
    victim_o = '0;
    node     = '0;
    nxt      = '0;
    b        = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      b        = ~tree[node];
      victim_o = (victim_o << 1) | WAY_W'(b);
      nxt      = {node, 1'b0} + (WAY_W+1)'(1) + (WAY_W+1)'(b);
      node     = nxt[WAY_W-1:0];
    end
  end

endmodule

// File: rtl/lru_state_store.sv
// Per-set pseudo-LRU storage with an IDLE/LOOKUP/RESP sequencer around the external update_LRU stage.
module lru_state_store
  import cache_pkg::*;
#(
  parameter int a_size = DEF_A_SIZE,
  parameter int sets   = DEF_SETS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [$clog2(sets)-1:0]   req_set,
  input  logic                      req_hit,
  input  logic [$clog2(a_size)-1:0] req_way,
  output logic [a_size-2:0]         LRU_bits,
  output logic [$clog2(a_size)-1:0] block_select,
  input  logic [a_size-2:0]         returned,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [$clog2(a_size)-1:0] resp_way,
  output logic                      resp_victim
);

  localparam int WAY_W = way_w(a_size);
  localparam int LRU_W = lru_w(a_size);
  localparam int SET_W = $clog2(sets);

  lru_state_e        state_q, state_d;
  logic [SET_W-1:0]  set_q;
  logic              hit_q;
  logic [WAY_W-1:0]  way_q;
  logic [WAY_W-1:0]  resp_way_q;
  logic              resp_victim_q;
  logic [LRU_W-1:0]  mem_q [sets];
  logic [LRU_W-1:0]  cur_bits;
  logic [WAY_W-1:0]  victim;

  assign cur_bits = mem_q[set_q];

  plru_victim #(
    .a_size (a_size)
  ) u_victim (
    .lru_i    (cur_bits),
    .victim_o (victim)
  );

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    LRU_bits     = '0;
    block_select = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        LRU_bits     = cur_bits;
        block_select = hit_q ? way_q : victim;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset has priority, so a transaction caught in LOOKUP never writes back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      set_q         <= '0;
      hit_q         <= 1'b0;
      way_q         <= '0;
      resp_way_q    <= '0;
      resp_victim_q <= 1'b0;
      for (int i = 0; i < sets; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        set_q <= req_set;
        hit_q <= req_hit;
        way_q <= req_way;
      end
      if (state_q == LOOKUP) begin
        mem_q[set_q]  <= returned;
        resp_way_q    <= block_select;
        resp_victim_q <= ~hit_q;
      end
    end
  end

  assign resp_way    = resp_way_q;
  assign resp_victim = resp_victim_q;

endmodule

// File: tb/tb_lru_state_store.sv
// Bench for lru_state_store: directed table, reset corners, randomized traffic, and a 2-way instance.
module tb_lru_state_store;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_hit, resp_valid, resp_ready, resp_victim;
  logic [5:0] req_set;
  logic [2:0] req_way, block_select, resp_way;
  logic [6:0] LRU_bits, returned;

  logic       d2_req_valid, d2_req_ready, d2_req_hit, d2_resp_valid, d2_resp_ready, d2_resp_victim;
  logic [1:0] d2_req_set;
  logic [0:0] d2_req_way, d2_LRU_bits, d2_block_select, d2_returned, d2_resp_way;

  bit         use_rand;
  logic [6:0] rand_ret;
  int         model_mem [64];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // update_LRU stand-in: set every node on the touched way's path to that way's direction.
  function automatic logic [6:0] upd8(input logic [6:0] bits, input int way);
    int b, node, d;
    b = int'(bits);
    node = 0;
    for (int l = 2; l >= 0; l--) begin
      d = (way >> l) & 1;
      if (d != 0) b = b | (1 << node);
      else        b = b & ~(1 << node);
      node = 2 * node + 1 + d;
    end
    return b[6:0];
  endfunction

  function automatic int victim_of(input int bits);
    int node, v, d;
    node = 0;
    v = 0;
    repeat (3) begin
      d = ((bits >> node) & 1) ^ 1;
      v = 2 * v + d;
      node = 2 * node + 1 + d;
    end
    return v;
  endfunction

  assign returned    = use_rand ? rand_ret : upd8(LRU_bits, int'(block_select));
  assign d2_returned = d2_block_select;

  lru_state_store #(.a_size(8), .sets(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_set      (req_set),
    .req_hit      (req_hit),
    .req_way      (req_way),
    .LRU_bits     (LRU_bits),
    .block_select (block_select),
    .returned     (returned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_way     (resp_way),
    .resp_victim  (resp_victim)
  );

  lru_state_store #(.a_size(2), .sets(4)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (d2_req_valid),
    .req_ready    (d2_req_ready),
    .req_set      (d2_req_set),
    .req_hit      (d2_req_hit),
    .req_way      (d2_req_way),
    .LRU_bits     (d2_LRU_bits),
    .block_select (d2_block_select),
    .returned     (d2_returned),
    .resp_valid   (d2_resp_valid),
    .resp_ready   (d2_resp_ready),
    .resp_way     (d2_resp_way),
    .resp_victim  (d2_resp_victim)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_way"}, 32'(resp_way), 32'd0);
    chk({tag, "_resp_victim"}, 32'(resp_victim), 32'd0);
    chk({tag, "_lru_bits"}, 32'(LRU_bits), 32'd0);
    chk({tag, "_block_select"}, 32'(block_select), 32'd0);
  endtask

  task automatic access(input int s, input bit h, input int w, input int exp_lru,
                        input int exp_way, input int hold);
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_set    = 6'(s);
    req_hit    = h;
    req_way    = 3'(w);
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("lookup_bits", 32'(LRU_bits), 32'(exp_lru));
    chk("lookup_sel", 32'(block_select), 32'(exp_way));
    chk("lookup_ready", 32'(req_ready), 32'd0);
    model_mem[s] = use_rand ? int'(rand_ret) : int'(upd8(7'(exp_lru), exp_way));
    @(posedge clk); #1;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_way", 32'(resp_way), 32'(exp_way));
    chk("resp_victim", 32'(resp_victim), 32'(!h));
    chk("resp_ready_low", 32'(req_ready), 32'd0);
    chk("resp_idle_drive", 32'({LRU_bits, block_select}), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_way", 32'(resp_way), 32'(exp_way));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_idle_ready", 32'(req_ready), 32'd1);
    chk("back_idle_valid", 32'(resp_valid), 32'd0);
  endtask

  task automatic access2(input int s, input int exp_way);
    d2_req_valid = 1'b1;
    d2_req_set   = 2'(s);
    d2_req_hit   = 1'b0;
    @(posedge clk); #1;
    d2_req_valid = 1'b0;
    chk("d2_lookup_sel", 32'(d2_block_select), 32'(exp_way));
    @(posedge clk); #1;
    chk("d2_resp_valid", 32'(d2_resp_valid), 32'd1);
    chk("d2_resp_way", 32'(d2_resp_way), 32'(exp_way));
    chk("d2_resp_victim", 32'(d2_resp_victim), 32'd1);
    @(posedge clk); #1;
    chk("d2_idle_ready", 32'(d2_req_ready), 32'd1);
  endtask

  typedef struct {
    int set;
    bit hit;
    int way;
    int lru_in;
    int exp_way;
    int hold;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, w, ev;
    bit h;

    tbl[0] = '{5,  1'b0, 0, 'h00, 7, 0};
    tbl[1] = '{5,  1'b0, 0, 'h45, 3, 0};
    tbl[2] = '{9,  1'b1, 2, 'h00, 2, 0};
    tbl[3] = '{5,  1'b0, 0, 'h56, 5, 5};
    tbl[4] = '{9,  1'b0, 0, 'h02, 7, 0};
    tbl[5] = '{5,  1'b1, 0, 'h73, 0, 1};
    tbl[6] = '{5,  1'b0, 0, 'h70, 6, 0};
    tbl[7] = '{10, 1'b0, 0, 'h00, 7, 0};

    rst = 1'b1;
    req_valid = 1'b0; req_set = '0; req_hit = 1'b0; req_way = '0; resp_ready = 1'b1;
    d2_req_valid = 1'b0; d2_req_set = '0; d2_req_hit = 1'b0; d2_req_way = '0; d2_resp_ready = 1'b1;
    use_rand = 1'b0; rand_ret = '0;
    for (int i = 0; i < 64; i++) model_mem[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("d2_reset_ready", 32'(d2_req_ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      access(tbl[i].set, tbl[i].hit, tbl[i].way, tbl[i].lru_in, tbl[i].exp_way, tbl[i].hold);

    // Reset while in LOOKUP: no write-back, everything clears.
    req_valid = 1'b1; req_set = 6'd5; req_hit = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_lookup_bits", 32'(LRU_bits), 32'(model_mem[5]));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs("rst_lookup");
    for (int i = 0; i < 64; i++) model_mem[i] = 0;
    access(5, 1'b0, 0, 0, 7, 0);
    access(9, 1'b0, 0, 0, 7, 0);

    // Reset while holding a response.
    req_valid = 1'b1; req_set = 6'd9; req_hit = 1'b1; req_way = 3'd4; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_resp_pre_valid", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    chk_reset_outputs("rst_resp");
    for (int i = 0; i < 64; i++) model_mem[i] = 0;
    access(9, 1'b0, 0, 0, 7, 0);

    // Randomized traffic against the per-set model.
    for (int i = 0; i < 160; i++) begin
      s = (i % 4 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3));
      h = 1'($urandom_range(0, 1));
      w = int'($urandom_range(0, 7));
      use_rand = 1'($urandom_range(0, 1));
      rand_ret = 7'($urandom_range(0, 127));
      ev = h ? w : victim_of(model_mem[s]);
      access(s, h, w, model_mem[s], ev, int'($urandom_range(0, 2)));
    end
    use_rand = 1'b0;

    // Two-way instance: alternating misses on one set, untouched neighbour.
    access2(0, 1);
    access2(0, 0);
    access2(0, 1);
    access2(0, 0);
    access2(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
